regbank_dump: RTL
=================

Name: regbank_dump

Overview:
- Parametrised successor register bank for the datapath: two read ports, one write port, one asynchronous debug read port.
- Adds optional hardwired-zero register 0, optional write-to-read bypass, and a sequential dump engine.
- The dump engine streams every register to the debug unit over a valid/ready handshake, one word per accepted beat.
- Sits in the ID stage; the dump port feeds the debug/UART serializer.

Parameters:
addr_bits, 5, register address width; depth = 2^addr_bits
word_wide, 32, register data width
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary
BYPASS, 1, 1 = same-cycle write data forwarded to readData1/readData2; 0 = no forwarding

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high
regWrite  input  1  write enable
writeReg  input  addr_bits  write address
writeData  input  word_wide  write data
readReg1  input  addr_bits  read port 1 address
readReg2  input  addr_bits  read port 2 address
readData1  output  word_wide  read port 1 data (combinational)
readData2  output  word_wide  read port 2 data (combinational)
readRegFromDebug  input  addr_bits  debug read address
readDataToDebug  output  word_wide  debug read data (combinational, never bypassed)
dump_start  input  1  request full-bank dump; honoured only when idle
dump_ready  input  1  consumer accepts current beat
dump_valid  output  1  beat valid
dump_addr  output  addr_bits  register index of current beat
dump_data  output  word_wide  register value of current beat
dump_last  output  1  current beat is index depth-1
dump_busy  output  1  dump engine not IDLE
dump_done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (sync, clock edge with reset=1): all registers become 0; FSM goes to IDLE; dump_valid, dump_busy, dump_done and dump_last become 0; dump_addr and dump_data become 0. Reset has priority over writes and dump activity, including a dump in progress.
- Write: on rising edge, if regWrite, banco[writeReg] <= writeData. With ZERO_REG=1 a write to index 0 is discarded.
- Read: readDataN = banco[readRegN]. With ZERO_REG=1 and index 0, the result is 0.
- Bypass (BYPASS=1): if regWrite and writeReg==readRegN and the write is not discarded, readDataN = writeData in the same cycle.
- readDataToDebug always returns the stored array value, with zero forcing but no bypass.
- FSM states:
  - IDLE: dump_valid=0. dump_start=1 -> SEND, loading beat 0.
  - SEND: dump_valid=1. dump_valid&dump_ready at an edge:
    - if dump_addr==depth-1 -> DONE;
    - else dump_addr+1 and load that beat.
    - No acceptance: dump_addr and dump_data hold stable.
  - DONE: dump_valid=0, dump_done=1 for exactly one cycle -> IDLE.
- Beat load: dump_data captures the array value (zero-forced) as it stands before the loading edge. A write at the same edge is not included. Later writes to an already-loaded index do not alter dump_data.
- Latency: first beat is valid the cycle after dump_start. Throughput is 1 beat/cycle with dump_ready held high. A full dump with ready=1 takes depth cycles of valid plus 1 cycle of done.
- dump_start is ignored in SEND and DONE; it does not queue.
- dump_last = dump_valid & (dump_addr==depth-1).
- dump_busy = 1 in SEND and DONE.
- Normal reads and writes continue unaffected during a dump.

Test Plan:
1. Reset then read: assert reset 1 cycle; readReg1=5, readReg2=31, readRegFromDebug=0 -> all outputs 0; dump_valid=0, dump_busy=0.
2. Write/read/zero: write 0xDEADBEEF to reg 7, then write 0x1234 to reg 0; next cycle readReg1=7 -> 0xDEADBEEF, readReg2=0 -> 0 (ZERO_REG=1).
3. Bypass: regWrite=1, writeReg=3, writeData=0xA5A5A5A5, readReg1=3 in the same cycle -> readData1=0xA5A5A5A5; readDataToDebug with address 3 -> old value 0 until after the edge. With BYPASS=0 -> readData1=0.
4. Full dump, ready=1: preload reg k = k+0x100 (k≥1), pulse dump_start -> 32 consecutive beats with addr 0..31 and data 0, 0x101..0x11F; dump_last only on addr 31; dump_done pulses once the next cycle; dump_busy then returns to 0.
5. Backpressure + concurrent write: during a dump hold dump_ready=0 at beat addr 4 for 3 cycles while writing reg 4=0xFFFF and reg 9=0x99 -> addr 4 data unchanged and stable across stall; beat 9 shows 0x99. A second dump_start mid-dump is ignored (exactly 32 beats).
6. Reset mid-dump: reset asserted while dump_addr=10 -> next cycle dump_valid=0, dump_busy=0, no dump_done, all registers 0; a new dump_start restarts at addr 0.

Source files
------------

// File: rtl/regbank_dump.sv
// Register bank with two combinational read ports, one write port, a
// never-bypassed debug read port, optional hardwired-zero register 0,
// optional write-to-read forwarding and a valid/ready dump engine that
// streams every register, in index order, to the debug serializer.
module regbank_dump #(
    parameter int addr_bits = 5,
    parameter int word_wide = 32,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 regWrite,
    input  logic [addr_bits-1:0] writeReg,
    input  logic [word_wide-1:0] writeData,
    input  logic [addr_bits-1:0] readReg1,
    input  logic [addr_bits-1:0] readReg2,
    output logic [word_wide-1:0] readData1,
    output logic [word_wide-1:0] readData2,
    input  logic [addr_bits-1:0] readRegFromDebug,
    output logic [word_wide-1:0] readDataToDebug,
    input  logic                 dump_start,
    input  logic                 dump_ready,
    output logic                 dump_valid,
    output logic [addr_bits-1:0] dump_addr,
    output logic [word_wide-1:0] dump_data,
    output logic                 dump_last,
    output logic                 dump_busy,
    output logic                 dump_done
);

    localparam int depth = 1 << addr_bits;
    localparam logic [addr_bits-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } dump_state_t;

    // Storage is flops rather than block RAM: every read is combinational
    // and the whole bank must clear on reset.
    logic [word_wide-1:0] banco [depth];
    logic                 write_ok;
    logic [depth-1:0]     write_sel;

    dump_state_t          state_reg, state_next;
    logic [addr_bits-1:0] dump_addr_reg, dump_addr_next;
    logic [word_wide-1:0] dump_data_reg, dump_data_next;
    logic [addr_bits-1:0] dump_addr_inc;

    // A write to register 0 is dropped entirely when it is hardwired to zero,
    // so it is neither stored nor forwarded.
    assign write_ok = regWrite && !((ZERO_REG != 0) && (writeReg == '0));

    // One-hot write decode, one enable per register
    generate
        for (genvar gi = 0; gi < depth; gi++) begin : g_write_sel
            assign write_sel[gi] = write_ok && (writeReg == addr_bits'(gi));
        end
    endgenerate

    // Register array: synchronous clear, otherwise decoded write
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) begin
                banco[i] <= '0;
            end
        end else begin
            for (int i = 0; i < depth; i++) begin
                if (write_sel[i]) begin
                    banco[i] <= writeData;
                end
            end
        end
    end

    // Stored value with register-0 forcing; never includes forwarding
    function automatic logic [word_wide-1:0] stored(input logic [addr_bits-1:0] a);
        if ((ZERO_REG != 0) && (a == '0)) begin
            return '0;
        end
        return banco[a];
    endfunction

    assign readData1 = ((BYPASS != 0) && write_ok && (writeReg == readReg1)) ? writeData
                                                                            : stored(readReg1);
    assign readData2 = ((BYPASS != 0) && write_ok && (writeReg == readReg2)) ? writeData
                                                                            : stored(readReg2);
    assign readDataToDebug = stored(readRegFromDebug);

    // Dump engine state, beat index and captured beat data
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            dump_addr_reg <= '0;
            dump_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            dump_addr_reg <= dump_addr_next;
            dump_data_reg <= dump_data_next;
        end
    end

    assign dump_addr_inc = dump_addr_reg + addr_bits'(1);

    // Next-state logic; a beat captures the array as it stands before the
    // loading edge, so a write on that same edge lands after the snapshot.
    always_comb begin
        state_next     = state_reg;
        dump_addr_next = dump_addr_reg;
        dump_data_next = dump_data_reg;
        case (state_reg)
            IDLE: begin
                if (dump_start) begin
                    state_next     = SEND;
                    dump_addr_next = '0;
                    dump_data_next = stored('0);
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (dump_addr_reg == LAST_ADDR) begin
                        state_next = DONE;
                    end else begin
                        dump_addr_next = dump_addr_inc;
                        dump_data_next = stored(dump_addr_inc);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dump_valid = (state_reg == SEND);
    assign dump_done  = (state_reg == DONE);
    assign dump_busy  = (state_reg != IDLE);
    assign dump_addr  = dump_addr_reg;
    assign dump_data  = dump_data_reg;
    assign dump_last  = dump_valid && (dump_addr_reg == LAST_ADDR);

endmodule
